// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter slice.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  // Widest requester vector the index helper accepts.
  localparam int unsigned ARB_MAX_N = 64;

  // Binary index of a one-hot (or zero) vector; zero input yields 0.
  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_N-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (vec[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/psel_n.sv
// Combinational N-way priority selector: highest set index of req wins.
module psel_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  // Scan upward so the highest requesting index overwrites lower ones.
  always_comb begin
    gnt = '0;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant, fixed or round-robin
// priority, and a grant lock for multi-cycle ownership.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter arb_mode_e   MODE  = ARB_RR,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic             lock,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] last_next;
  logic [N-1:0]     below_last;
  logic [N-1:0]     masked;
  logic [N-1:0]     gnt_masked;
  logic [N-1:0]     gnt_full;
  logic [N-1:0]     winner;
  logic [N-1:0]     gnt_next;
  logic             hold;

  // Requesters strictly below the last winner; empty in fixed mode so the
  // full-vector selector always decides.
  always_comb begin
    below_last = '0;
    for (int unsigned i = 0; i < N; i++) begin
      below_last[i] = (MODE == ARB_RR) && (i < 32'(last));
    end
    masked = req & below_last;
  end

  psel_n #(.N(N)) u_psel_masked (
    .req (masked),
    .en  (en),
    .gnt (gnt_masked)
  );

  psel_n #(.N(N)) u_psel_full (
    .req (req),
    .en  (en),
    .gnt (gnt_full)
  );

  // Status outputs derive from the registered grant only.
  always_comb begin
    gnt_valid = |gnt;
    gnt_idx   = IDX_W'(onehot_to_idx(ARB_MAX_N'(gnt)));
    hold      = lock && gnt_valid && (|(req & gnt));
    winner    = (|masked) ? gnt_masked : gnt_full;
  end

  // Next grant and pointer: disable, lock hold, idle, then arbitrate.
  always_comb begin
    gnt_next  = gnt;
    last_next = last;
    if (!en) begin
      gnt_next = '0;
    end else if (hold) begin
      gnt_next = gnt;
    end else if (req == '0) begin
      gnt_next = '0;
    end else begin
      gnt_next = winner;
      if (MODE == ARB_RR) begin
        last_next = IDX_W'(onehot_to_idx(ARB_MAX_N'(winner)));
      end
    end
  end

  // Grant and round-robin pointer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt  <= '0;
      last <= '0;
    end else begin
      gnt  <= gnt_next;
      last <= last_next;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench: directed cases on N=4 (RR and fixed), then random
// stimulus on N=1,3,4,8 against a priority-order reference model.
module tb_rr_arbiter;
  import arb_pkg::*;

  localparam int ND = 5;
  localparam int NN   [ND] = '{4, 4, 1, 3, 8};
  localparam bit ISRR [ND] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       lock = 1'b0;
  logic [7:0] req_v [ND];

  logic [3:0] g0, g1;
  logic [0:0] g2;
  logic [2:0] g3;
  logic [7:0] g4;
  logic [1:0] i0, i1, i3;
  logic [0:0] i2;
  logic [2:0] i4;
  logic       v0, v1, v2, v3, v4;

  logic [7:0] gw [ND];
  logic [7:0] iw [ND];
  logic       vw [ND];

  int checks = 0;
  int failures = 0;

  // reference model state
  bit         m_valid [ND];
  int         m_idx   [ND];
  int         m_last  [ND];
  logic [7:0] p_req   [ND];
  logic       p_en, p_lock;
  int         wt      [ND][8];

  always #5 clock = ~clock;

  rr_arbiter #(.N(4), .MODE(ARB_RR)) u_rr4 (
    .clock(clock), .reset_n(reset_n), .req(req_v[0][3:0]), .en(en), .lock(lock),
    .gnt(g0), .gnt_valid(v0), .gnt_idx(i0));
  rr_arbiter #(.N(4), .MODE(ARB_FIXED)) u_fx4 (
    .clock(clock), .reset_n(reset_n), .req(req_v[1][3:0]), .en(en), .lock(lock),
    .gnt(g1), .gnt_valid(v1), .gnt_idx(i1));
  rr_arbiter #(.N(1), .MODE(ARB_RR)) u_rr1 (
    .clock(clock), .reset_n(reset_n), .req(req_v[2][0:0]), .en(en), .lock(lock),
    .gnt(g2), .gnt_valid(v2), .gnt_idx(i2));
  rr_arbiter #(.N(3), .MODE(ARB_RR)) u_rr3 (
    .clock(clock), .reset_n(reset_n), .req(req_v[3][2:0]), .en(en), .lock(lock),
    .gnt(g3), .gnt_valid(v3), .gnt_idx(i3));
  rr_arbiter #(.N(8), .MODE(ARB_RR)) u_rr8 (
    .clock(clock), .reset_n(reset_n), .req(req_v[4]), .en(en), .lock(lock),
    .gnt(g4), .gnt_valid(v4), .gnt_idx(i4));

  always_comb begin
    gw[0] = 8'(g0); gw[1] = 8'(g1); gw[2] = 8'(g2); gw[3] = 8'(g3); gw[4] = g4;
    iw[0] = 8'(i0); iw[1] = 8'(i1); iw[2] = 8'(i2); iw[3] = 8'(i3); iw[4] = 8'(i4);
    vw[0] = v0; vw[1] = v1; vw[2] = v2; vw[3] = v3; vw[4] = v4;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_valid[d] = 1'b0;
      m_idx[d]   = 0;
      m_last[d]  = 0;
      p_req[d]   = '0;
      for (int i = 0; i < 8; i++) wt[d][i] = 0;
    end
    p_en   = 1'b0;
    p_lock = 1'b0;
  endtask

  // Predict the grant produced by the inputs currently driven.
  task automatic model_next();
    for (int d = 0; d < ND; d++) begin
      int n;
      logic [7:0] r;
      bit found;
      n = NN[d];
      r = 8'(int'(req_v[d]) & ((1 << n) - 1));
      p_req[d] = r;
      if (!en) begin
        m_valid[d] = 1'b0;
      end else if (lock && m_valid[d] && r[m_idx[d]]) begin
        // ownership kept
      end else if (r == 8'd0) begin
        m_valid[d] = 1'b0;
      end else begin
        found = 1'b0;
        if (!ISRR[d]) begin
          for (int k = n - 1; k >= 0; k--)
            if (!found && r[k]) begin found = 1'b1; m_idx[d] = k; end
        end else begin
          // priority order: last-1, last-2, ..., wrapping, ending at last
          for (int k = 1; k <= n; k++) begin
            int c;
            c = (m_last[d] + n - k) % n;
            if (!found && r[c]) begin found = 1'b1; m_idx[d] = c; end
          end
          m_last[d] = m_idx[d];
        end
        m_valid[d] = 1'b1;
      end
    end
    p_en   = en;
    p_lock = lock;
  endtask

  task automatic step();
    model_next();
    @(posedge clock);
    #1;
    for (int d = 0; d < ND; d++) begin
      logic [7:0] eg;
      eg = m_valid[d] ? 8'(1 << m_idx[d]) : 8'd0;
      chk($sformatf("gnt[%0d]", d), gw[d], eg);
      chk($sformatf("valid[%0d]", d), vw[d], m_valid[d]);
      chk($sformatf("idx[%0d]", d), iw[d], m_valid[d] ? m_idx[d] : 0);
      chk($sformatf("onehot[%0d]", d), $onehot0(gw[d]), 1);
      chk($sformatf("noreq[%0d]", d), gw[d] & ~p_req[d], 0);
      if (ISRR[d]) begin
        for (int i = 0; i < NN[d]; i++) begin
          if (!p_req[d][i] || gw[d][i]) wt[d][i] = 0;
          else if (p_en && !p_lock) begin
            wt[d][i]++;
            chk($sformatf("starve[%0d][%0d]", d, i), wt[d][i] < NN[d], 1);
          end
        end
      end
    end
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int d = 0; d < ND; d++) req_v[d] = v;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
  endtask

  logic [3:0] fx_req [10] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                              4'b0101, 4'b0110, 4'b1110, 4'b1111, 4'b1111};
  logic [3:0] fx_exp [10] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                              4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
  logic [3:0] rot_exp [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

  initial begin
    set_all(8'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gnt", gw[0], 0);
    chk("rst_idx", iw[0], 0);
    reset_n = 1'b1;

    // reset mid-grant takes effect immediately
    en = 1'b1;
    set_all(8'b0100);
    step();
    chk("pre_rst_gnt", gw[0], 8'b0100);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_gnt", gw[0], 0);
    chk("async_rst_idx", iw[0], 0);
    chk("async_rst_valid", vw[0], 0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // fixed priority table, last entry with en=0
    for (int k = 0; k < 10; k++) begin
      set_all(8'(fx_req[k]));
      en = (k != 9);
      step();
      chk($sformatf("fixed[%0d]", k), gw[1], 8'(fx_exp[k]));
    end

    // round-robin full rotation
    pulse_reset();
    en = 1'b1;
    lock = 1'b0;
    set_all(8'b1111);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rot[%0d]", k), gw[0], 8'(rot_exp[k]));
    end

    // lock holds, released by grantee dropping req
    pulse_reset();
    lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("lock[%0d]", k), gw[0], 8'b1000);
    end
    set_all(8'b0111);
    step();
    chk("lock_drop", gw[0], 8'b0100);

    // en=0 mid-rotation preserves the pointer
    lock = 1'b0;
    en = 1'b0;
    set_all(8'b1111);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("en_off[%0d]", k), gw[0], 0);
    end
    en = 1'b1;
    step();
    chk("en_resume", gw[0], 8'b0010);

    // random sweep with sticky requests
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < ND; d++) req_v[d] = req_v[d] ^ (8'($urandom) & 8'($urandom));
      en   = ($urandom_range(0, 9) != 0);
      lock = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
